// File: rtl/rv32i_mc_control_pkg.sv
// -----------------------------------------------------------------------------
// rv32i_mc_control_pkg
// Shared types for the multi-cycle RV32I control path.
//   opcode_t          - base RV32I major opcodes this core executes
//   l/s/b_type_t      - funct3 encodings for loads, stores and branches
//   alu_op_t          - {funct7[5], funct3} ALU operation encoding
//   ctrl_state_t      - sequencer states
//   imm_t             - immediate format select
//   wb_sel_t/pc_sel_t - register write-back and next-PC source selects
//   dec_t             - control fields produced by rv32i_decode
// -----------------------------------------------------------------------------
package rv32i_mc_control_pkg;

    localparam int XLEN = 32;

    typedef enum logic [6:0] {
        OP_LUI    = 7'b0110111,
        OP_AUIPC  = 7'b0010111,
        OP_JAL    = 7'b1101111,
        OP_JALR   = 7'b1100111,
        OP_BRANCH = 7'b1100011,
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_IMM    = 7'b0010011,
        OP_REG    = 7'b0110011
    } opcode_t;

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } l_type_t;

    typedef enum logic [2:0] {
        SB = 3'b000,
        SH = 3'b001,
        SW = 3'b010
    } s_type_t;

    typedef enum logic [2:0] {
        BEQ  = 3'b000,
        BNE  = 3'b001,
        BLT  = 3'b100,
        BGE  = 3'b101,
        BLTU = 3'b110,
        BGEU = 3'b111
    } b_type_t;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SLL  = 4'b0001,
        ALU_SLT  = 4'b0010,
        ALU_SLTU = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_OR   = 4'b0110,
        ALU_AND  = 4'b0111,
        ALU_SUB  = 4'b1000,
        ALU_SRA  = 4'b1101
    } alu_op_t;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_TRAP
    } ctrl_state_t;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_t;

    typedef enum logic [1:0] {
        WB_ALU,
        WB_MDR,
        WB_PC4,
        WB_IMM
    } wb_sel_t;

    typedef enum logic [1:0] {
        PC_PLUS4,
        PC_ALU,
        PC_ALU_ALIGN
    } pc_sel_t;

    // Instruction fetches are always full words.
    localparam logic [2:0] FETCH_SIZE = LW;

    typedef struct packed {
        logic       illegal;
        logic       is_load;
        logic       is_store;
        logic       is_branch;
        logic [3:0] alu_op;     // EXEC-state ALU operation
        logic       alu_src_a;  // 1 = PC
        logic       alu_src_b;  // 1 = immediate
        imm_t       imm_sel;
        wb_sel_t    wb_sel;     // WB-state write-back source
        pc_sel_t    pc_sel;     // WB-state next-PC source
    } dec_t;

endpackage

// File: rtl/rv32i_decode.sv
// -----------------------------------------------------------------------------
// rv32i_decode
// Purely combinational instruction decoder: maps the latched instruction word
// to the control fields the sequencer needs, plus an illegal-encoding flag.
//   instr - instruction register contents
//   dec   - decoded control fields (dec_t)
// -----------------------------------------------------------------------------
module rv32i_decode
    import rv32i_mc_control_pkg::*;
(
    input  logic [XLEN-1:0] instr,
    output dec_t            dec
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    // Register indices and immediate bits are consumed by the datapath only.
    logic unused_fields;
    assign unused_fields = ^{instr[24:15], instr[11:7]};

    always_comb begin
        // NOTE: every field gets a default before the case so no path infers a latch.
        dec         = '0;
        dec.alu_op  = ALU_ADD;
        dec.imm_sel = IMM_I;
        dec.wb_sel  = WB_ALU;
        dec.pc_sel  = PC_PLUS4;

        case (opcode)
            OP_REG: begin
                dec.alu_op  = {funct7[5], funct3};
                // Only ADD/SUB and SRL/SRA have an alternate funct7.
                dec.illegal = !((funct7 == 7'b0000000) ||
                                ((funct7 == 7'b0100000) &&
                                 ((funct3 == 3'b000) || (funct3 == 3'b101))));
            end
            OP_IMM: begin
                dec.alu_src_b = 1'b1;
                // funct7[5] only selects SRAI; elsewhere those bits are immediate.
                dec.alu_op    = {(funct3 == 3'b101) & funct7[5], funct3};
            end
            OP_LOAD: begin
                dec.is_load   = 1'b1;
                dec.alu_src_b = 1'b1;
                dec.wb_sel    = WB_MDR;
                dec.illegal   = !(funct3 inside {LB, LH, LW, LBU, LHU});
            end
            OP_STORE: begin
                dec.is_store  = 1'b1;
                dec.alu_src_b = 1'b1;
                dec.imm_sel   = IMM_S;
                dec.illegal   = (funct3 > SW);
            end
            OP_BRANCH: begin
                dec.is_branch = 1'b1;
                dec.alu_src_a = 1'b1;
                dec.alu_src_b = 1'b1;
                dec.imm_sel   = IMM_B;
                dec.illegal   = (funct3 == 3'b010) || (funct3 == 3'b011);
            end
            OP_JAL: begin
                dec.alu_src_a = 1'b1;
                dec.alu_src_b = 1'b1;
                dec.imm_sel   = IMM_J;
                dec.wb_sel    = WB_PC4;
                dec.pc_sel    = PC_ALU;
            end
            OP_JALR: begin
                dec.alu_src_b = 1'b1;
                dec.wb_sel    = WB_PC4;
                dec.pc_sel    = PC_ALU_ALIGN;
            end
            OP_LUI: begin
                dec.imm_sel = IMM_U;
                dec.wb_sel  = WB_IMM;
            end
            OP_AUIPC: begin
                dec.alu_src_a = 1'b1;
                dec.alu_src_b = 1'b1;
                dec.imm_sel   = IMM_U;
            end
            default: dec.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/rv32i_mc_control.sv
// -----------------------------------------------------------------------------
// rv32i_mc_control
// Multi-cycle control sequencer: walks each instruction through FETCH, DECODE,
// EXEC, MEM and WB, drives every datapath enable/select, owns the memory-port
// request handshake, counts retirements and traps on illegal encodings.
//   clk, rst          - clock, asynchronous active-high reset
//   instr             - instruction register contents (valid from DECODE)
//   mem_rdata_ir      - memory read data (only its arrival matters, via mem_ready)
//   mem_ready         - memory completes the current request this cycle
//   branch_taken      - comparator result for the latched branch
//   mem_req/we/size   - memory request, write strobe, access size
//   ir_we ... reg_we  - datapath register enables
//   alu_op/src_a/src_b, imm_sel, wb_sel, pc_sel - datapath selects
//   retire, instret   - retirement pulse and running count
//   illegal           - sticky trap flag
// -----------------------------------------------------------------------------
module rv32i_mc_control
    import rv32i_mc_control_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] instr,
    input  logic [XLEN-1:0] mem_rdata_ir,
    input  logic            mem_ready,
    input  logic            branch_taken,
    output logic            mem_req,
    output logic            mem_we,
    output logic [2:0]      mem_size,
    output logic            ir_we,
    output logic            mdr_we,
    output logic            pc_we,
    output logic            reg_we,
    output logic [3:0]      alu_op,
    output logic            alu_src_a,
    output logic            alu_src_b,
    output logic [2:0]      imm_sel,
    output logic [1:0]      wb_sel,
    output logic [1:0]      pc_sel,
    output logic            retire,
    output logic [31:0]     instret,
    output logic            illegal
);

    ctrl_state_t state;
    dec_t        dec;

    // The data itself goes straight to the IR/MDR in the datapath.
    logic unused_rdata;
    assign unused_rdata = ^mem_rdata_ir;

    rv32i_decode u_decode (
        .instr (instr),
        .dec   (dec)
    );

    // ------------------------------------------------------------------
    // Sequencer state, retirement counter and trap flag.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst) begin
            state   <= S_FETCH;
            instret <= '0;
            illegal <= 1'b0;
        end else begin
            case (state)
                S_FETCH: if (mem_ready) state <= S_DECODE;
                S_DECODE: begin
                    if (dec.illegal) begin
                        state   <= S_TRAP;
                        illegal <= 1'b1;
                    end else begin
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (dec.is_load || dec.is_store) state <= S_MEM;
                    else if (dec.is_branch)          state <= S_FETCH;
                    else                             state <= S_WB;
                end
                S_MEM: if (mem_ready) state <= dec.is_store ? S_FETCH : S_WB;
                S_WB:   state <= S_FETCH;
                S_TRAP: state <= S_TRAP;
                default: state <= S_TRAP;
            endcase

            // Plain 32-bit add wraps from all-ones to zero.
            if (retire) instret <= instret + 32'd1;
        end
    end

    // ------------------------------------------------------------------
    // Control outputs, combinational from state and instruction.
    // ------------------------------------------------------------------
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_size  = FETCH_SIZE;
        ir_we     = 1'b0;
        mdr_we    = 1'b0;
        pc_we     = 1'b0;
        reg_we    = 1'b0;
        retire    = 1'b0;
        alu_op    = ALU_ADD;
        alu_src_a = 1'b0;
        alu_src_b = 1'b0;
        imm_sel   = dec.imm_sel;
        wb_sel    = WB_ALU;
        pc_sel    = PC_PLUS4;

        case (state)
            S_FETCH: begin
                mem_req = 1'b1;
                ir_we   = mem_ready;
            end
            S_EXEC: begin
                alu_op    = dec.alu_op;
                alu_src_a = dec.alu_src_a;
                alu_src_b = dec.alu_src_b;
                if (dec.is_branch) begin
                    pc_we  = 1'b1;
                    retire = 1'b1;
                    pc_sel = branch_taken ? PC_ALU : PC_PLUS4;
                end
            end
            S_MEM: begin
                mem_req  = 1'b1;
                mem_we   = dec.is_store;
                mem_size = instr[14:12];
                if (mem_ready) begin
                    if (dec.is_store) begin
                        pc_we  = 1'b1;
                        retire = 1'b1;
                    end else begin
                        mdr_we = 1'b1;
                    end
                end
            end
            S_WB: begin
                reg_we = 1'b1;
                pc_we  = 1'b1;
                retire = 1'b1;
                wb_sel = dec.wb_sel;
                pc_sel = dec.pc_sel;
            end
            default: ;
        endcase

        // Strobes drop as soon as reset rises, abandoning any open request.
        if (rst) begin
            mem_req = 1'b0;
            mem_we  = 1'b0;
            ir_we   = 1'b0;
            mdr_we  = 1'b0;
            pc_we   = 1'b0;
            reg_we  = 1'b0;
            retire  = 1'b0;
        end
    end

endmodule

// File: doc/rv32i_mc_control.md
# rv32i_mc_control

Multi-cycle control sequencer for the RV32I core. Takes the latched instruction word and datapath status and walks each instruction through FETCH, DECODE, EXEC, MEM and WB. In each state it drives every datapath enable, mux select and ALU operation. It also owns the single memory-port request handshake, retires instructions, counts retirements and traps on illegal encodings.

## Interface
- XLEN, 32, data and instruction width
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- instr  in  XLEN  instruction register contents (valid from DECODE onward)
- mem_rdata_ir  in  XLEN  memory read data; only its arrival is used here, via mem_ready
- mem_ready  in  1  memory completes the current request this cycle
- branch_taken  in  1  comparator result for the latched B-type funct3
- mem_req, mem_we  out  1  memory request and write strobe
- mem_size  out  3  funct3 of the load/store; 3'b010 during fetch
- ir_we, mdr_we, pc_we, reg_we  out  1  register enables
- alu_op  out  4  {funct7[5], funct3} encoding per r_typeInstr
- alu_src_a  out  1  0 = rs1, 1 = PC
- alu_src_b  out  1  0 = rs2, 1 = immediate
- imm_sel  out  3  immediate format, imm_t
- wb_sel  out  2  0 = ALU, 1 = MDR, 2 = PC+4, 3 = immediate
- pc_sel  out  2  0 = PC+4, 1 = ALU result, 2 = ALU result & ~1
- retire  out  1  one-cycle pulse on the final cycle of each instruction
- instret  out  32  retired-instruction count
- illegal  out  1  sticky trap flag

## Operation
- States (ctrl_state_t): S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP.
- S_FETCH:
  - mem_req = 1, mem_we = 0.
  - Hold until mem_ready = 1; that same cycle ir_we = 1, then go to S_DECODE.
- S_DECODE: one cycle, no enables.
  - Opcode not in opcode_t → S_TRAP.
  - R_type with funct7 outside {0000000, 0100000}, or 0100000 with funct3 ∉ {000, 101} → S_TRAP.
  - L_type funct3 ∉ l_typeInstr → S_TRAP.
  - S_type funct3 > 010 → S_TRAP.
  - B_type funct3 ∈ {010, 011} → S_TRAP.
  - Otherwise → S_EXEC.
- S_EXEC, ALU settings by type:
  - R_type: a = rs1, b = rs2, alu_op = {f7[5], f3}.
  - I_type: a = rs1, b = imm(I), alu_op = {f3 == 101 ? f7[5] : 0, f3}.
  - L/S: rs1 + imm(I/S), ADD.
  - JAL, B_type, APUIPC: PC + imm(J/B/U), ADD.
  - JALR: rs1 + imm(I), ADD.
  - LUI: no ALU use.
- S_EXEC, next state:
  - L/S → S_MEM.
  - B_type → retire here: pc_we = 1, pc_sel = branch_taken ? 1 : 0.
  - All others → S_WB.
- S_MEM:
  - mem_req = 1, mem_we = (S_type), mem_size = f3.
  - Hold until mem_ready.
  - Load: mdr_we = 1, → S_WB.
  - Store: retire, pc_we = 1, pc_sel = 0, → S_FETCH.
- S_WB: reg_we = 1, pc_we = 1, retire, → S_FETCH.
  - wb_sel: load = 1, JAL/JALR = 2, LUI = 3, else 0.
  - pc_sel: JAL = 1, JALR = 2, else 0.
- S_TRAP: illegal = 1, all strobes 0. Only rst exits.
- instret increments by 1 on every retire and wraps from 0xFFFFFFFF to 0.

## Timing
- Reset:
  - state = S_FETCH, instret = 0, illegal = 0.
  - All strobes are 0 while rst = 1; mem_req is gated by !rst.
  - First request is in the first cycle after release.
- All outputs are combinational from state and instr. Only state, instret and illegal are registered.
- Cycle counts, with mem_ready in the first request cycle:
  - Branch: 3.
  - R, I, JAL, JALR, LUI, APUIPC, store: 4.
  - Load: 5.
  - Each wait cycle adds 1.
- mem_req stays high and mem_we/mem_size stay stable until mem_ready is sampled high. There is no cancel.
- rst mid-request drops mem_req immediately; any pending memory response is ignored.
- Writes to x0 are the regfile's concern; reg_we is still asserted.

## Structure
- Add to package parameters:
  - ctrl_state_t.
  - imm_t {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J}.
  - wb_sel and pc_sel enums.
- Reuse opcode_t and the funct3 enums.
- One sub-module, rv32i_decode, is combinational. It maps instr to control fields plus an illegal flag. The FSM stays in rv32i_mc_control.

## Test plan
- add x3,x1,x2 (0x002081B3), mem_ready always high → ir_we in cycle 0; alu_op = 0000, b = rs2 in cycle 2; reg_we, wb_sel = 0, retire in cycle 3; instret = 1.
- lw x5,8(x1) (0x0080A283), mem_ready low for 2 MEM cycles → mem_req/mem_size = 010 held for 3 cycles; mdr_we on the ready cycle; wb_sel = 1; 7 cycles total.
- sw x2,4(x1) (0x0020A223) → mem_we = 1 in S_MEM; retire with no reg_we.
- beq x0,x0,+8 (0x00000463), branch_taken = 1 → pc_we, pc_sel = 1 in cycle 2; retire; back to S_FETCH.
- instr 0x00000000 → S_TRAP after DECODE; illegal stays 1; no mem_req; rst clears it.
- Assert rst during a fetch wait → mem_req falls in the same cycle; instret = 0.
